// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start qualification, mid-bit sampling, optional
// parity, stop check, and a one-entry valid/ready holding register.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | start bit seen, confirm it is still low at mid-bit
// DATA   | sampling data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, delivers the character
// BREAK  | stop bit was low, wait for the line to return high
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_clk_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_err, par_err_nxt;
  logic                 deliver;
  logic                 stop_low;
  logic                 rxd_meta, rxd_s;

  // synchroniser idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      par_err <= par_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    par_err_nxt = par_err;
    deliver     = 1'b0;
    stop_low    = 1'b0;
    if (rx_clk_en) begin
      cnt_nxt = cnt + 4'd1;
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (!rxd_s) state_nxt = START;
        end
        START: begin
          if (cnt == 4'd7) begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            par_err_nxt = 1'b0;
            state_nxt   = rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          // counter wraps 15 -> 0, so the next bit period starts automatically
          if (cnt == 4'd15) begin
            shift_nxt[bit_idx] = rxd_s;
            bit_idx_nxt        = bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state_nxt = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (cnt == 4'd15) begin
            par_err_nxt = ((^shift) ^ rxd_s) != PARITY_ODD;
            state_nxt   = STOP;
          end
        end
        STOP: begin
          if (cnt == 4'd15) begin
            deliver   = 1'b1;
            stop_low  = !rxd_s;
            state_nxt = rxd_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          cnt_nxt = '0;
          if (rxd_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // a delivery wins over a same-cycle consume; overrun only if nobody took the old one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (deliver) begin
        rx_data       <= shift;
        rx_parity_err <= par_err;
        rx_frame_err  <= stop_low;
        rx_valid      <= 1'b1;
        rx_overrun    <= rx_valid && !rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserialises the asynchronous serial input using the 16x oversampling enable from the baud rate generator. Synchronises the line, detects and qualifies start bits, samples data at mid-bit, checks optional parity and the stop bit. Presents each received character through a one-entry valid/ready holding register to the bus-side logic. Instantiated beside the transmitter in the UART top, sharing the baud generator.

## Interface
- DATA_BITS, 8: character width, legal 5..8.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

- clk  in  1  system clock; the block's only clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_clk_en  in  1  single-cycle 16x oversampling tick.
- rxd  in  1  serial line, asynchronous, idle high.
- rx_data  out  DATA_BITS  received character, LSB = first bit on the line.
- rx_valid  out  1  rx_data and the error flags are valid; held until consumed.
- rx_ready  in  1  consumer accepts the character when rx_valid && rx_ready.
- rx_parity_err  out  1  parity mismatch for the held character; qualified by rx_valid.
- rx_frame_err  out  1  stop bit sampled low for the held character; qualified by rx_valid.
- rx_overrun  out  1  one-cycle pulse: the held character was overwritten before it was consumed.

## Operation
- rxd passes through a 2-flop synchroniser whose flops reset to 1. All logic below uses the synchronised value rxd_s.
- A 4-bit tick counter advances only on rx_clk_en. Sampling and state decisions occur only on rx_clk_en cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on a tick with rxd_s==0, go to START with counter=0.
  - START: on the tick where counter==7 (mid start bit), sample rxd_s.
    - If rxd_s==0: go to DATA with counter=0 and bit index=0.
    - If rxd_s==1: treat as a glitch and return to IDLE. No output.
  - DATA: on the tick where counter==15, sample rxd_s into shift[bit index] and reset the counter.
    - After sampling bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: on the tick where counter==15, sample rxd_s.
    - Error = (XOR of the data bits ^ sampled bit) != PARITY_ODD.
    - Go to STOP.
  - STOP: on the tick where counter==15, sample rxd_s and deliver the character.
    - If rxd_s==1: go to IDLE.
    - If rxd_s==0: set frame error and go to BREAK.
  - BREAK: wait for a tick with rxd_s==1, then go to IDLE. This prevents a held-low line from producing repeated characters.
- Delivery (the cycle after the stop-bit tick):
  - rx_data loads the shift register, the flags load, and rx_valid is set to 1.
  - If rx_valid was 1 and rx_ready was 0 in the delivery cycle, pulse rx_overrun for one cycle. The new character replaces the old one.
  - A frame-error character is still delivered, with rx_frame_err=1.
- Consumption: rx_valid && rx_ready clears rx_valid on the next edge. rx_data and the flags hold their values.
- Simultaneous delivery and consumption in the same cycle: rx_valid stays 1 with the new character, and no overrun is raised.
- Parity error and frame error can both be set for the same character.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0. FSM=IDLE, counter=0, synchroniser=1.
- Reset asserted mid-frame aborts the frame immediately. No character is delivered afterwards.
- Input latency: 2 clk from rxd to rxd_s.
- Start detection resolution: 1 tick.
- Data bit k is sampled 8+16*(k+1) ticks after start detection, i.e. at mid-bit.
- rx_valid rises 1 clk after the stop-bit sampling tick.
- Frame length in ticks: 16*(1+DATA_BITS+PARITY_EN+1). The next start bit can be detected on the first tick after returning to IDLE.
- rx_overrun is high for exactly 1 clk.

## Test plan
- DATA_BITS=8, no parity: send 0xA5 with ticks every 4 clk -> rx_valid=1 with rx_data=0xA5, rx_parity_err=0, rx_frame_err=0; rx_valid clears 1 clk after rx_ready=1.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 0 -> no error. Send 0x03 with parity bit 1 -> rx_parity_err=1, rx_data=0x03.
- Low glitch of 5 ticks on an idle line -> FSM returns to IDLE, rx_valid stays 0. Then send 0x3C -> rx_data=0x3C.
- Send 0x55 with the stop bit low, then hold the line low for 40 ticks, then high, then send 0x12 -> first character has rx_frame_err=1; no character during the low period; then rx_data=0x12 with rx_frame_err=0.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_overrun pulses 1 clk and rx_data=0x22. Repeat with rx_ready=1 in the delivery cycle -> no overrun.
- Assert rst after data bit 3 of 0xF0, release it, then send 0x0F -> all outputs return to reset values; only 0x0F is delivered.
